barrel_shifter: RTL and testbench

BARREL_SHIFTER -- requirements
Module: barrel_shifter

---
 rtl/barrel_shifter_pkg.sv | 16 +
 rtl/barrel_shifter_if.sv | 32 +++
 rtl/barrel_shifter_stage.sv | 32 +++
 rtl/barrel_shifter.sv | 56 +++++
 tb/tb_barrel_shifter.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the barrel shifter: default sizes and operation encodings.
package barrel_shifter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    // Operation encodings carried on ShiftSelect; 101..111 are reserved (pass-through).
    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_ROL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_e;

endpackage : barrel_shifter_pkg

// File: rtl/barrel_shifter_if.sv
// Operand/result bundle between a requester (master) and the shifter (slave).
interface barrel_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);

    logic             InValid;
    logic [2:0]       ShiftSelect;
    logic [AMT_W-1:0] ShifterAmount;
    logic [WIDTH-1:0] OriginB;
    logic [WIDTH-1:0] ShiftedB;
    logic             OutValid;

    modport master (
        output InValid,
        output ShiftSelect,
        output ShifterAmount,
        output OriginB,
        input  ShiftedB,
        input  OutValid
    );

    modport slave (
        input  InValid,
        input  ShiftSelect,
        input  ShifterAmount,
        input  OriginB,
        output ShiftedB,
        output OutValid
    );

endinterface : barrel_shifter_if

// File: rtl/barrel_shifter_stage.sv
// One mux layer of the log2 barrel: moves data by a fixed DIST when enabled.
module barrel_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    // Select between the unshifted word and the word moved by DIST for the given operation.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (shift_op_e'(op_i))
                OP_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
                OP_SLL:  data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
                OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                OP_ROL:  data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
                // The sign bit is never disturbed by earlier SRA stages, so data_i MSB is OriginB[15].
                OP_SRA:  data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
                default: data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule : barrel_stage

// File: rtl/barrel_shifter.sv
// Single-cycle registered barrel shifter/rotator built from four barrel_stage layers.
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic              Clk,
    input  logic              RstN,
    barrel_shifter_if.slave   bus
);

    logic [WIDTH-1:0] stage_s [0:AMT_W];
    logic [WIDTH-1:0] shifted_d;
    logic [WIDTH-1:0] shifted_q;
    logic             out_valid_q;

    assign stage_s[0] = bus.OriginB;

    // Stage k moves by 2**k and is controlled by ShifterAmount[k].
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (stage_s[k]),
            .en_i   (bus.ShifterAmount[k]),
            .op_i   (bus.ShiftSelect),
            .data_o (stage_s[k+1])
        );
    end

    // Next result: new barrel output on a valid cycle, otherwise hold.
    always_comb begin
        if (bus.InValid) begin
            shifted_d = stage_s[AMT_W];
        end else begin
            shifted_d = shifted_q;
        end
    end

    // Result and valid registers; reset discards anything in flight.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            shifted_q   <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            shifted_q   <= shifted_d;
            out_valid_q <= bus.InValid;
        end
    end

    assign bus.ShiftedB = shifted_q;
    assign bus.OutValid = out_valid_q;

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Directed and randomized self-checking bench for barrel_shifter.
module tb_barrel_shifter;

    logic Clk;
    logic RstN;
    int   checks;
    int   errors;

    barrel_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

    barrel_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Independent reference: uses native operators rather than a staged barrel.
    function automatic logic [15:0] model(input logic [2:0] op, input logic [3:0] amt,
                                          input logic [15:0] b);
        logic [31:0] dbl;
        dbl = {b, b};
        case (op)
            3'b000:  model = b >> amt;
            3'b001:  model = b << amt;
            3'b010:  model = 16'(dbl >> amt);
            3'b011:  model = 16'((dbl << amt) >> 16);
            3'b100:  model = 16'($signed(b) >>> amt);
            default: model = b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one set of operands, let one edge pass, then sample the result.
    task automatic step(input logic v, input logic [2:0] op, input logic [3:0] amt,
                        input logic [15:0] b);
        @(negedge Clk);
        bus.InValid       = v;
        bus.ShiftSelect   = op;
        bus.ShifterAmount = amt;
        bus.OriginB       = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [3:0] amt,
                            input logic [15:0] b, input logic [15:0] exp);
        step(1'b1, op, amt, b);
        check({tag, "_data"}, bus.ShiftedB, exp);
        check({tag, "_valid"}, {15'd0, bus.OutValid}, 16'd1);
    endtask

    logic [15:0] exp_data;
    logic        exp_valid;
    logic        v;
    logic [2:0]  op;
    logic [3:0]  amt;
    logic [15:0] b;

    initial begin
        checks = 0;
        errors = 0;
        RstN = 1'b0;
        bus.InValid = 1'b0;
        bus.ShiftSelect = 3'b000;
        bus.ShifterAmount = 4'd0;
        bus.OriginB = 16'h0000;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_data", bus.ShiftedB, 16'h0000);
        check("reset_valid", {15'd0, bus.OutValid}, 16'd0);
        @(negedge Clk);
        RstN = 1'b1;

        // Single-bit moves of 0xD000.
        op_check("srl_d000_1", 3'b000, 4'd1, 16'hD000, 16'h6800);
        op_check("sll_d000_1", 3'b001, 4'd1, 16'hD000, 16'hA000);
        op_check("ror_d000_1", 3'b010, 4'd1, 16'hD000, 16'h6800);
        op_check("rol_d000_1", 3'b011, 4'd1, 16'hD000, 16'hA001);
        op_check("sra_d000_1", 3'b100, 4'd1, 16'hD000, 16'hE800);

        // Maximum distance on 0x8001.
        op_check("ror_8001_15", 3'b010, 4'd15, 16'h8001, 16'h0003);
        op_check("sra_8001_15", 3'b100, 4'd15, 16'h8001, 16'hFFFF);
        op_check("sll_8001_15", 3'b001, 4'd15, 16'h8001, 16'h8000);
        op_check("srl_8001_15", 3'b000, 4'd15, 16'h8001, 16'h0001);
        op_check("rol_8001_4",  3'b011, 4'd4,  16'h8001, 16'h0018);

        // Zero distance and reserved encodings pass the operand through.
        op_check("srl_amt0", 3'b000, 4'd0, 16'h1234, 16'h1234);
        op_check("sll_amt0", 3'b001, 4'd0, 16'h1234, 16'h1234);
        op_check("ror_amt0", 3'b010, 4'd0, 16'h1234, 16'h1234);
        op_check("rol_amt0", 3'b011, 4'd0, 16'h1234, 16'h1234);
        op_check("sra_amt0", 3'b100, 4'd0, 16'h9234, 16'h9234);
        op_check("rsv111",   3'b111, 4'd7, 16'h1234, 16'h1234);
        op_check("rsv101",   3'b101, 4'd3, 16'hBEEF, 16'hBEEF);
        op_check("rsv110",   3'b110, 4'd9, 16'hCAFE, 16'hCAFE);

        // Idle cycle holds the result and drops valid.
        step(1'b0, 3'b001, 4'd2, 16'hFFFF);
        check("idle_hold", bus.ShiftedB, 16'hCAFE);
        check("idle_valid", {15'd0, bus.OutValid}, 16'd0);

        // Reset mid-stream while a valid result is present and InValid stays high.
        op_check("pre_reset", 3'b001, 4'd4, 16'h0ABC, 16'hABC0);
        bus.InValid = 1'b1;
        bus.OriginB = 16'h5555;
        #2;
        RstN = 1'b0;
        #1;
        check("rst_async_data", bus.ShiftedB, 16'h0000);
        check("rst_async_valid", {15'd0, bus.OutValid}, 16'd0);
        @(posedge Clk);
        #1;
        check("rst_hold_data", bus.ShiftedB, 16'h0000);
        @(negedge Clk);
        RstN = 1'b1;
        op_check("post_reset", 3'b011, 4'd8, 16'h12AB, 16'hAB12);

        // Random back-to-back traffic against the reference model.
        exp_data = 16'hAB12;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            amt = 4'($urandom_range(0, 15));
            b   = 16'($urandom);
            if (v) begin
                exp_data = model(op, amt, b);
            end
            exp_valid = v;
            step(v, op, amt, b);
            check("rand_data", bus.ShiftedB, exp_data);
            check("rand_valid", {15'd0, bus.OutValid}, {15'd0, exp_valid});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_barrel_shifter
